// File: rtl/aes_pkg.sv
// Shared AES-128 definitions used by the cipher and decipher.
// Round count, key words, Rcon and the control-state encoding.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // One InvMixColumns column; byte a0 sits in the top bits.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction

endpackage

// File: rtl/aes_decipher_if.sv
// Request/result bundle between a block client and aes_decipher.
// The client is the master; the decipher core is the slave.
interface aes_decipher_if;
    import aes_pkg::*;

    logic         Start;
    logic [127:0] Cipher_Text;
    logic [127:0] Key;
    logic [127:0] Plain_Text;
    logic         Done;

    modport master (
        output Start, Cipher_Text, Key,
        input  Plain_Text, Done
    );

    modport slave (
        input  Start, Cipher_Text, Key,
        output Plain_Text, Done
    );

endinterface

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one byte, purely combinational.
// Byte i of the table is at bits [2047-8i -: 8].
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] w_idx;

    assign w_idx  = ~{i_byte, 3'b000};
    assign o_byte = ISBOX[w_idx -: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
// Byte i of the table is at bits [2047-8i -: 8].
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_idx;

    assign w_idx  = ~{i_byte, 3'b000};
    assign o_byte = SBOX[w_idx -: 8];

endmodule

// File: rtl/aes_decipher.sv
// Iterative AES-128 inverse cipher: 10 key-expansion cycles,
// one whitening cycle, then one inverse round per cycle.
module aes_decipher
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic          CLK,
    input  logic          Rst_n,
    aes_decipher_if.slave bus
);

    aes_state_e   r_state;
    logic [3:0]   r_kcnt;
    logic [3:0]   r_round;
    logic [127:0] r_ct;
    logic [127:0] r_data;
    logic [127:0] r_pt;
    logic         r_done;
    logic [127:0] r_rk [0:NR];

    logic [127:0] w_prev_rk;
    logic [127:0] w_next_rk;
    logic [31:0]  w_rot;
    logic [31:0]  w_subw;
    logic [31:0]  w_temp;
    logic [127:0] w_rk;
    logic [127:0] w_shift;
    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;

    // Key schedule step: RotWord/SubWord/Rcon on the last word.
    assign w_prev_rk = r_rk[r_kcnt];
    assign w_rot     = {w_prev_rk[23:0], w_prev_rk[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_ksb
        aes_sbox u_sbox (
            .i_byte (w_rot[31-8*b -: 8]),
            .o_byte (w_subw[31-8*b -: 8])
        );
    end

    assign w_temp = w_subw ^ {rcon(r_kcnt), 24'h000000};

    assign w_next_rk[127:96] = w_prev_rk[127:96] ^ w_temp;
    assign w_next_rk[95:64]  = w_prev_rk[95:64] ^ w_next_rk[127:96];
    assign w_next_rk[63:32]  = w_prev_rk[63:32] ^ w_next_rk[95:64];
    assign w_next_rk[31:0]   = w_prev_rk[31:0] ^ w_next_rk[63:32];

    // The round counter selects rk10 for whitening and rk0 last.
    assign w_rk = r_rk[r_round];

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            localparam int DST = 4 * c + r;
            assign w_shift[127-8*DST -: 8] = r_data[127-8*SRC -: 8];
            aes_inv_sbox u_isbox (
                .i_byte (w_shift[127-8*DST -: 8]),
                .o_byte (w_sub[127-8*DST -: 8])
            );
        end
        assign w_mix[127-32*c -: 32] =
            inv_mix_col(w_ark[127-32*c -: 32]);
    end

    assign w_ark = w_sub ^ w_rk;

    assign bus.Plain_Text = r_pt;
    assign bus.Done       = r_done;

    // Control FSM with round-key file and data path registers.
    always_ff @(posedge CLK) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_pt    <= '0;
            r_kcnt  <= '0;
            r_round <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        r_ct     <= bus.Cipher_Text;
                        r_rk[0]  <= bus.Key;
                        r_kcnt   <= '0;
                        r_done   <= 1'b0;
                        r_state  <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    if (r_kcnt < 4'(NR)) begin
                        r_rk[r_kcnt + 4'd1] <= w_next_rk;
                        r_kcnt <= r_kcnt + 4'd1;
                    end
                    if (r_kcnt == 4'(NR - 1)) begin
                        r_round <= 4'(NR);
                        r_state <= ROUND;
                    end
                end
                ROUND: begin
                    if (r_round == 4'(NR)) begin
                        r_data  <= r_ct ^ w_rk;
                        r_round <= r_round - 4'd1;
                    end else if (r_round != 4'd0) begin
                        r_data  <= w_mix;
                        r_round <= r_round - 4'd1;
                    end else begin
                        r_pt    <= w_ark;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher.sv
// Self-checking bench for aes_decipher: known-answer table,
// back-to-back, reset corners and random loopback.
module tb_aes_decipher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    aes_decipher_if bus ();

    aes_decipher #(.NR(10)) dut (
        .CLK   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t tbl [3];

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: field inverse then affine map.
    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]}
                   ^ 8'h63;
    endfunction

    // Forward AES-128 on byte arrays, used to make ciphertexts.
    function automatic logic [127:0] aes_enc(input logic [127:0] key,
                                             input logic [127:0] pt);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] t0, rc, a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                t0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[t0];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    t[4*c+rw] = sb[s[4*((c+rw)%4)+rw]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1];
                a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
                    s[4*c+3] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1;
                    s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block: pulse Start, scramble inputs while busy, wait for Done.
    task automatic run_one(input logic [127:0] key,
                           input logic [127:0] ct,
                           output logic [127:0] pt,
                           output int lat);
        @(negedge clk);
        bus.Key = key;
        bus.Cipher_Text = ct;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Key = rnd128();
        bus.Cipher_Text = rnd128();
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.Done) break;
            bus.Start = (lat < 18) ? 1'($urandom) : 1'b0;
            bus.Key = rnd128();
            bus.Cipher_Text = rnd128();
        end
        bus.Start = 1'b0;
        pt = bus.Plain_Text;
    endtask

    // Reset pulse landing on edge E0+at while a block is in flight.
    task automatic reset_mid(input int at);
        int n_done;
        @(negedge clk);
        bus.Key = tbl[1].key;
        bus.Cipher_Text = tbl[1].ct;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (at - 1) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk($sformatf("rst%0d_done", at), 128'(bus.Done), 128'd0);
        chk($sformatf("rst%0d_pt", at), bus.Plain_Text, 128'd0);
        n_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.Done) n_done++;
        end
        chk($sformatf("rst%0d_idle", at), 128'(n_done), 128'd0);
    endtask

    logic [127:0] got;
    logic [127:0] k;
    logic [127:0] p;
    int lat;
    int seen;
    int last;
    int cyc;
    int n_done;

    initial begin
        for (int x = 0; x < 256; x++) sb[x] = calc_sbox(8'(x));

        tbl[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                   ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                   pt:  128'h00112233445566778899aabbccddeeff};
        tbl[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                   ct:  128'h3925841d02dc09fbdc118597196a0b32,
                   pt:  128'h3243f6a8885a308d313198a2e0370734};
        tbl[2] = '{key: 128'h0,
                   ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                   pt:  128'h0};

        bus.Start = 1'b0;
        bus.Key = '0;
        bus.Cipher_Text = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_done", 128'(bus.Done), 128'd0);
        chk("reset_pt", bus.Plain_Text, 128'd0);

        foreach (tbl[i]) begin
            run_one(tbl[i].key, tbl[i].ct, got, lat);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd21);
            chk($sformatf("vec%0d_pt", i), got, tbl[i].pt);
            repeat (3) begin
                @(posedge clk); #1;
                chk($sformatf("vec%0d_hold_done", i),
                    128'(bus.Done), 128'd1);
                chk($sformatf("vec%0d_hold_pt", i),
                    bus.Plain_Text, tbl[i].pt);
            end
        end

        // Start held high, the two known vectors alternating.
        @(negedge clk);
        bus.Key = tbl[0].key;
        bus.Cipher_Text = tbl[0].ct;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        last = 0;
        cyc = 0;
        while (seen < 4 && cyc < 120) begin
            if (bus.Done) begin
                chk($sformatf("b2b%0d_pt", seen),
                    bus.Plain_Text, tbl[seen % 2].pt);
                chk($sformatf("b2b%0d_gap", seen),
                    128'(cyc - last), (seen == 0) ? 128'd21 : 128'd22);
                last = cyc;
                seen++;
                if (seen < 4) begin
                    bus.Key = tbl[seen % 2].key;
                    bus.Cipher_Text = tbl[seen % 2].ct;
                end else begin
                    bus.Start = 1'b0;
                end
            end else begin
                bus.Key = rnd128();
                bus.Cipher_Text = rnd128();
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.Start = 1'b0;
        chk("b2b_count", 128'(seen), 128'd4);

        reset_mid(5);
        reset_mid(15);
        run_one(tbl[0].key, tbl[0].ct, got, lat);
        chk("after_rst_lat", 128'(lat), 128'd21);
        chk("after_rst_pt", got, tbl[0].pt);

        // Reset and Start together while holding a result.
        @(negedge clk);
        rst_n = 1'b0;
        bus.Key = tbl[1].key;
        bus.Cipher_Text = tbl[1].ct;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.Start = 1'b0;
        chk("rst_start_done", 128'(bus.Done), 128'd0);
        chk("rst_start_pt", bus.Plain_Text, 128'd0);
        n_done = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.Done) n_done++;
        end
        chk("rst_start_idle", 128'(n_done), 128'd0);

        for (int i = 0; i < 1000; i++) begin
            k = rnd128();
            p = rnd128();
            run_one(k, aes_enc(k, p), got, lat);
            chk($sformatf("loop%0d_lat", i), 128'(lat), 128'd21);
            chk($sformatf("loop%0d_pt", i), got, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
